pipe_ctrl: RTL

Pipeline hazard and multi-cycle-unit sequencer for the 5-stage MIPS32 core. Watches the instruction in ID and the one in EX and drives the stall and flush controls of the PC, IF/ID and ID/EX registers. Detects load-use hazards and redirects, and sequences the shared multiply/divide unit so that it accepts one operation at a time. Holds HI/LO readers until the result is committed.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/md_timer.sv | 67 ++++++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline hazard / mul-div sequencer.
// Imported by pipe_ctrl and md_timer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam int MUL_CYCLES_DEFAULT = 4;
    localparam int DIV_CYCLES_DEFAULT = 32;

    // Counter width: holds (max cycles - 1), never narrower than one bit.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int m;
        m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

    localparam int CNT_W = cnt_width(MUL_CYCLES_DEFAULT, DIV_CYCLES_DEFAULT);

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic md_start;
    } hz_ctrl_t;

endpackage

// File: rtl/md_timer.sv
// Occupancy timer for the shared multiply/divide unit: IDLE -> BUSY (N cycles)
// -> DONE (one cycle, HI/LO written) -> IDLE.
module md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int CW         = cnt_width(MUL_CYCLES, DIV_CYCLES)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      is_div,
    output md_state_e state,
    output logic      busy,
    output logic      done
);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                // cnt == 0 marks the last busy cycle; hold it there.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard detection and stall/flush control for the 5-stage core, plus issue
// sequencing of the shared mul/div unit and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_md,
    input  logic        id_md_div,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_rd,
    input  logic        ex_reg_wr,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_to_pc,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    md_state_e md_state;
    logic      md_idle;
    logic      lu_hz;
    logic      hl_hz;
    logic      mc_hz;
    hz_ctrl_t  ctrl;

    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (ctrl.md_start),
        .is_div (id_md_div),
        .state  (md_state),
        .busy   (md_busy),
        .done   (md_done)
    );

    assign md_idle = (md_state == IDLE);

    always_comb begin
        lu_hz = ex_mem_rd && ex_reg_wr && (ex_waddr != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_waddr)) ||
                 (id_uses_rt && (id_rt == ex_waddr)));
        hl_hz = id_reads_hilo && !md_idle;
        mc_hz = id_is_md && !md_idle;
    end

    // A redirect squashes the ID instruction, so any hazard it raised is moot.
    always_comb begin
        ctrl = '0;
        if (ex_to_pc) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (lu_hz || hl_hz || mc_hz) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else begin
            ctrl.md_start = id_is_md && md_idle;
        end
    end

    assign pc_stall    = ctrl.pc_stall;
    assign if_id_stall = ctrl.if_id_stall;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign md_start    = ctrl.md_start;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
